coco_dac_mux: RTL and testbench
===============================

# coco_dac_mux

Parametrised CoCo sound/joystick DAC block. It selects the sound source from the 6-bit DAC, the cassette, the cartridge or silence using SEL B/SEL A. It compares the DAC against one of four joystick axes to drive the comparator (hilo) line. Unlike the fixed single-cycle version, it models comparator settling time, mixes in the 1-bit sound, and slew-limits the audio output to suppress pops. It sits between the PIA outputs and the audio and joystick-input paths of the CoCo core.

## Interface
Parameters:
- DAC_BITS, 6: DAC width.
- JOY_BITS, 8: per-axis joystick width. Must be >= DAC_BITS.
- AUD_BITS, 12: audio width. Must be >= DAC_BITS.
- SETTLE, 8: comparator settling cycles after a DAC or select change. 0 is legal.
- SND_LEVEL, 12'h400: level added to the sound when the 1-bit sound is high.
- RAMP_STEP, 16: maximum audio change per cycle. 0 means no slew limit (output jumps to target).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- joy_in  in  4*JOY_BITS  four axes; axis k = joy_in[k*JOY_BITS +: JOY_BITS].
- dac  in  DAC_BITS  DAC value.
- cass_snd  in  AUD_BITS  cassette audio.
- cart_snd  in  AUD_BITS  cartridge audio.
- snden  in  1  analog sound enable.
- snd  in  1  1-bit sound.
- selb, sela  in  1 each  mux select; sel = {selb,sela}.
- hilo  out  1  comparator output.
- settled  out  1  high when the comparator is settled.
- sound  out  AUD_BITS  audio output.

## Operation
- Joystick axis: axis = joy_in axis index sel (0..3). cmp = (axis[JOY_BITS-1 -: DAC_BITS] >= dac), unsigned. Equality gives 1, so full-scale values match.
- Change detection: registered dac_q and sel_q. chg = (dac != dac_q) || (sel != sel_q). dac_q and sel_q update every cycle.
- Settle counter cnt, 0..SETTLE:
  - chg → cnt <= SETTLE; hilo holds.
  - else cnt != 0 → cnt <= cnt-1; hilo holds.
  - else (cnt == 0) → hilo <= cmp.
- settled = (cnt == 0) && !chg, registered alongside cnt.
- Sound target:
  - base = 0 when !snden. Otherwise by sel: 00 → dac << (AUD_BITS-DAC_BITS); 01 → cass_snd; 10 → cart_snd; 11 → 0.
  - target = snd ? min(base + SND_LEVEL, 2^AUD_BITS - 1) : base. Saturating add, evaluated at AUD_BITS+1 width.
  - snd is not gated by snden.
- Slew limiter, RAMP_STEP > 0:
  - sound < target → sound <= sound + min(RAMP_STEP, target - sound).
  - sound > target → sound <= sound - min(RAMP_STEP, sound - target).
  - equal → hold.
  - Never overshoots.
- Slew limiter, RAMP_STEP == 0 → sound <= target.

## Timing
- Reset values: hilo=0, sound=0, cnt=SETTLE, settled=(SETTLE==0), dac_q=0, sel_q=0.
- Change sampled at edge t → hilo first reflects the new cmp at edge t+SETTLE+1.
- settled rises at edge t+SETTLE. With SETTLE=0: settled low one cycle, hilo updates at t+1.
- A new change while counting restarts the count at SETTLE. No partial update occurs.
- Joystick-only changes (dac and sel stable) do not restart settling. With cnt==0, hilo tracks the axis with 1-cycle latency.
- Sound reaches a new target after ceil(|target - sound| / RAMP_STEP) cycles. A target change mid-ramp retargets on the next cycle.
- Reset mid-ramp or mid-settle forces the reset values on that edge.

## Test plan
- Reset, then sel=00, dac=6'h20, joy axis0=8'h81, SETTLE=8 → hilo=0 until 9 cycles after the dac write, then hilo=1. settled high from cycle 8.
- Full scale: dac=6'h3F, axis=8'hFC, sel=00 → hilo=1 (equality). Then axis=8'hF8 → hilo=0 one cycle later, with no resettling.
- Rewrite dac every 4 cycles with SETTLE=8 → hilo never changes and settled stays 0. Stop writing → hilo updates 9 cycles after the last write.
- snden=1, sel=00, dac=6'h3F, RAMP_STEP=16 → sound ramps 0,16,32,…. It reaches 12'hFC0 after 252 cycles, with no overshoot.
- snden=0, snd=1, SND_LEVEL=12'h400 → target 12'h400. Then snden=1, sel=01, cass_snd=12'hE00 → target saturates to 12'hFFF.
- sel=11, snden=1 → target 0, so sound ramps down. Assert reset mid-ramp → sound=0, hilo=0 on the next edge.

Source files
------------

// File: rtl/coco_dac_mux.sv
// coco_dac_mux: CoCo sound source mux and joystick comparator DAC.
// Selects the audio source, models comparator settling after DAC/select
// changes, mixes in the 1-bit sound and slew-limits the audio output.
module coco_dac_mux #(
  parameter int                  DAC_BITS  = 6,
  parameter int                  JOY_BITS  = 8,
  parameter int                  AUD_BITS  = 12,
  parameter int                  SETTLE    = 8,
  parameter logic [AUD_BITS-1:0] SND_LEVEL = 12'h400,
  parameter int                  RAMP_STEP = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*JOY_BITS-1:0] joy_in,
  input  logic [DAC_BITS-1:0]   dac,
  input  logic [AUD_BITS-1:0]   cass_snd,
  input  logic [AUD_BITS-1:0]   cart_snd,
  input  logic                  snden,
  input  logic                  snd,
  input  logic                  selb,
  input  logic                  sela,
  output logic                  hilo,
  output logic                  settled,
  output logic [AUD_BITS-1:0]   sound
);

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);
  // A step wider than the output range behaves like "jump to target".
  localparam int unsigned AUD_MAX = (2 ** AUD_BITS) - 1;
  localparam int unsigned STEP_CLAMP =
    (RAMP_STEP > AUD_MAX) ? AUD_MAX : RAMP_STEP;
  localparam logic [AUD_BITS-1:0] STEP = STEP_CLAMP[AUD_BITS-1:0];

  // Saturating add evaluated one bit wider than the audio path.
  function automatic logic [AUD_BITS-1:0] sat_add(
    input logic [AUD_BITS-1:0] a,
    input logic [AUD_BITS-1:0] b
  );
    logic [AUD_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AUD_BITS] ? {AUD_BITS{1'b1}} : s[AUD_BITS-1:0];
  endfunction

  // Move cur toward tgt by at most STEP, never overshooting.
  function automatic logic [AUD_BITS-1:0] slew(
    input logic [AUD_BITS-1:0] cur,
    input logic [AUD_BITS-1:0] tgt
  );
    logic [AUD_BITS-1:0] diff;
    if (RAMP_STEP == 0) return tgt;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > STEP) ? cur + STEP : tgt;
    end
    diff = cur - tgt;
    return (diff > STEP) ? cur - STEP : tgt;
  endfunction

  logic [1:0]          sel;
  logic [JOY_BITS-1:0] axis;
  logic                cmp;
  logic [DAC_BITS-1:0] dac_q;
  logic [1:0]          sel_q;
  logic                chg;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [AUD_BITS-1:0] dac_ext;
  logic [AUD_BITS-1:0] base;
  logic [AUD_BITS-1:0] target;

  assign sel = {selb, sela};

  // Axis pick, comparator and change detection.
  always_comb begin
    axis = joy_in[JOY_BITS-1:0];
    case (sel)
      2'd0: axis = joy_in[0*JOY_BITS +: JOY_BITS];
      2'd1: axis = joy_in[1*JOY_BITS +: JOY_BITS];
      2'd2: axis = joy_in[2*JOY_BITS +: JOY_BITS];
      2'd3: axis = joy_in[3*JOY_BITS +: JOY_BITS];
      default: axis = joy_in[JOY_BITS-1:0];
    endcase
    cmp = (axis[JOY_BITS-1 -: DAC_BITS] >= dac);
    chg = (dac != dac_q) || (sel != sel_q);
    if (chg)
      cnt_nxt = CNT_MAX;
    else if (cnt != '0)
      cnt_nxt = cnt - CNT_W'(1);
    else
      cnt_nxt = cnt;
  end

  // Settle counter; hilo only samples the comparator once the count is spent.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_q   <= '0;
      sel_q   <= '0;
      cnt     <= CNT_MAX;
      settled <= (SETTLE == 0);
      hilo    <= 1'b0;
    end else begin
      dac_q   <= dac;
      sel_q   <= sel;
      cnt     <= cnt_nxt;
      settled <= (cnt_nxt == '0) && !chg;
      if (!chg && cnt == '0)
        hilo <= cmp;
    end
  end

  // Audio target: selected source plus the optional 1-bit sound level.
  always_comb begin
    dac_ext = AUD_BITS'(dac) << (AUD_BITS - DAC_BITS);
    base    = '0;
    if (snden) begin
      case (sel)
        2'd0:    base = dac_ext;
        2'd1:    base = cass_snd;
        2'd2:    base = cart_snd;
        default: base = '0;
      endcase
    end
    target = snd ? sat_add(base, SND_LEVEL) : base;
  end

  // Slew-limited audio output.
  always_ff @(posedge clk) begin
    if (reset)
      sound <= '0;
    else
      sound <= slew(sound, target);
  end

endmodule

// File: tb/tb_coco_dac_mux.sv
// Directed bench for coco_dac_mux with default parameters.
// Expectations are queued with the cycle they apply to and checked as
// the design reaches that cycle.
module tb_coco_dac_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] joy_in;
  logic [5:0]  dac;
  logic [11:0] cass_snd;
  logic [11:0] cart_snd;
  logic        snden;
  logic        snd;
  logic        selb;
  logic        sela;
  logic        hilo;
  logic        settled;
  logic [11:0] sound;

  coco_dac_mux dut (
    .clk(clk), .reset(reset), .joy_in(joy_in), .dac(dac),
    .cass_snd(cass_snd), .cart_snd(cart_snd), .snden(snden), .snd(snd),
    .selb(selb), .sela(sela), .hilo(hilo), .settled(settled), .sound(sound)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    int          sig;   // 0 hilo, 1 settled, 2 sound
    logic [11:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   tests;
  int   fails;
  int   t;

  task automatic expect_at(input int at, input int sig, input logic [11:0] val, input string tag);
    exp_t e;
    int   pos;
    e.at = at; e.sig = sig; e.val = val; e.tag = tag;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].at > at) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [11:0] obs;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      case (e.sig)
        0:       obs = {11'b0, hilo};
        1:       obs = {11'b0, settled};
        default: obs = sound;
      endcase
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s @cyc %0d: observed %0h expected %0h", e.tag, cyc, obs, e.val);
      end
    end
  endtask

  // One clock: step past the active edge, sample on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drain();
    end
  endtask

  initial begin
    cyc = 0; tests = 0; fails = 0;
    reset = 1'b1; joy_in = '0; dac = '0; cass_snd = '0; cart_snd = '0;
    snden = 1'b0; snd = 1'b0; selb = 1'b0; sela = 1'b0;
    tick(2);

    // Reset state
    expect_at(cyc, 0, 12'h0, "rst_hilo");
    expect_at(cyc, 1, 12'h0, "rst_settled");
    expect_at(cyc, 2, 12'h0, "rst_sound");
    drain();

    // Basic settle: dac 0x20 vs axis0 0x81 (top bits 0x20, equal)
    reset = 1'b0; dac = 6'h20; joy_in[7:0] = 8'h81;
    t = cyc + 1;
    expect_at(t,     1, 12'h0, "s1_settled_t");
    expect_at(t + 7, 1, 12'h0, "s1_settled_t7");
    expect_at(t + 8, 1, 12'h1, "s1_settled_t8");
    expect_at(t + 8, 0, 12'h0, "s1_hilo_t8");
    expect_at(t + 9, 0, 12'h1, "s1_hilo_t9");
    tick(11);

    // Full scale equality, then joystick-only change
    dac = 6'h3F; joy_in[7:0] = 8'hFC;
    t = cyc + 1;
    expect_at(t + 8, 1, 12'h1, "fs_settled");
    expect_at(t + 9, 0, 12'h1, "fs_hilo_eq");
    tick(10);
    joy_in[7:0] = 8'hF8;
    t = cyc + 1;
    expect_at(t, 0, 12'h0, "fs_hilo_joy");
    expect_at(t, 1, 12'h1, "fs_no_resettle");
    tick(2);

    // Repeated DAC writes every 4 cycles hold hilo and keep settled low
    for (int i = 0; i < 5; i++) begin
      dac = (i % 2 == 1) ? 6'h11 : 6'h10;
      t = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        expect_at(t + k, 0, 12'h0, "rw_hilo_hold");
        expect_at(t + k, 1, 12'h0, "rw_settled_low");
      end
      tick(4);
    end
    expect_at(t + 7, 1, 12'h0, "rw_settled_t7");
    expect_at(t + 8, 1, 12'h1, "rw_settled_t8");
    expect_at(t + 8, 0, 12'h0, "rw_hilo_t8");
    expect_at(t + 9, 0, 12'h1, "rw_hilo_t9");
    tick(7);

    // Ramp up to dac 0x3F << 6 = 0xFC0 in 16-step increments
    snden = 1'b1; dac = 6'h3F;
    t = cyc + 1;
    expect_at(t,       2, 12'd16,   "ramp_first");
    expect_at(t + 1,   2, 12'd32,   "ramp_second");
    expect_at(t + 100, 2, 12'd1616, "ramp_mid");
    expect_at(t + 250, 2, 12'd4016, "ramp_t250");
    expect_at(t + 251, 2, 12'hFC0,  "ramp_reach");
    expect_at(t + 260, 2, 12'hFC0,  "ramp_no_overshoot");
    tick(262);

    // snden off with 1-bit sound: target 0x400, reached in 188 cycles
    snden = 1'b0; snd = 1'b1;
    t = cyc + 1;
    expect_at(t,       2, 12'hFB0, "snd_down_first");
    expect_at(t + 187, 2, 12'h400, "snd_level");
    expect_at(t + 190, 2, 12'h400, "snd_level_hold");
    tick(191);

    // Cassette 0xE00 + 0x400 saturates to 0xFFF; last step is partial
    snden = 1'b1; sela = 1'b1; cass_snd = 12'hE00;
    t = cyc + 1;
    expect_at(t,       2, 12'h410, "sat_first");
    expect_at(t + 190, 2, 12'hFF0, "sat_t190");
    expect_at(t + 191, 2, 12'hFFF, "sat_reach");
    expect_at(t + 195, 2, 12'hFFF, "sat_hold");
    tick(196);

    // sel=11 silence ramps down; axis3 full scale drives hilo high
    selb = 1'b1; sela = 1'b1; snd = 1'b0; joy_in[31:24] = 8'hFF;
    t = cyc + 1;
    expect_at(t,      2, 12'hFEF, "sil_first");
    expect_at(t + 1,  2, 12'hFDF, "sil_second");
    expect_at(t + 9,  0, 12'h1,   "sil_hilo");
    expect_at(t + 11, 2, 12'hF3F, "sil_t11");
    tick(12);

    // Reset mid-ramp
    reset = 1'b1;
    t = cyc + 1;
    expect_at(t, 2, 12'h0, "rst_mid_sound");
    expect_at(t, 0, 12'h0, "rst_mid_hilo");
    expect_at(t, 1, 12'h0, "rst_mid_settled");
    tick(1);
    reset = 1'b0;
    t = cyc + 1;
    expect_at(t + 3, 2, 12'h0, "post_rst_sound");
    tick(5);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $error("FAIL %s: never checked, expected %0h at cyc %0d", e.tag, e.val, e.at);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
